// File: rtl/factor_pkg.sv
// Shared types and constants for the factorization job controller.
// Slice helpers split N into the core's MSB/MID/LSB operand buses.
package factor_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_CHECK,
        S_RESULT
    } state_e;

    localparam int          N_DIGIT_DEF   = 64;
    localparam logic [31:0] SEED_STEP_DEF = 32'h9E3779B9;
    localparam int          VERIFY_LAT    = 2;

    localparam int MSB_W = 4;

    function automatic int mid_w(input int n);
        return n / 2 - 2;
    endfunction

    function automatic int mid_hi(input int n);
        return n - 5;
    endfunction

    function automatic int lsb_w(input int n);
        return n / 2 - 2;
    endfunction

endpackage

// File: rtl/factor_verify.sv
// Two-stage check that X*Y equals N with neither factor equal to one.
// Stage 1 registers the full product, stage 2 registers the verdict.
module factor_verify #(
    parameter int MAX_N_DIGIT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [MAX_N_DIGIT/2-1:0] i_x,
    input  logic [MAX_N_DIGIT/2-1:0] i_y,
    input  logic [MAX_N_DIGIT-1:0]   i_n,
    output logic                     o_ok
);

    localparam int HW = MAX_N_DIGIT / 2;

    logic [MAX_N_DIGIT-1:0] prod_q, prod_d;
    logic                   nontriv_q, nontriv_d;
    logic                   ok_q, ok_d;

    always_comb begin
        prod_d    = {{HW{1'b0}}, i_x} * {{HW{1'b0}}, i_y};
        nontriv_d = (i_x != HW'(1)) && (i_y != HW'(1));
        ok_d      = (prod_q == i_n) && nontriv_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q    <= '0;
            nontriv_q <= 1'b0;
            ok_q      <= 1'b0;
        end else begin
            prod_q    <= prod_d;
            nontriv_q <= nontriv_d;
            ok_q      <= ok_d;
        end
    end

    assign o_ok = ok_q;

endmodule

// File: rtl/factor_job_controller.sv
// Sequences factorization jobs on the p-bit core: init, run, verify,
// retry with a stepped seed, and hand back a result record.
module factor_job_controller
    import factor_pkg::*;
#(
    parameter int          MAX_N_DIGIT = N_DIGIT_DEF,
    parameter int          COUNTER_BIT = 32,
    parameter int          MAX_RETRY   = 4,
    parameter logic [31:0] SEED_STEP   = SEED_STEP_DEF,
    parameter int          INIT_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_N_valid,
    output logic                          o_N_ready,
    input  logic [MAX_N_DIGIT-1:0]        i_N,
    input  logic [31:0]                   i_seed,
    input  logic                          i_abort,
    output logic                          o_core_en,
    output logic [31:0]                   o_seed,
    output logic [MSB_W-1:0]              o_N_MSB,
    output logic [MAX_N_DIGIT/2-3:0]      o_N_MID,
    output logic [MAX_N_DIGIT/2-3:0]      o_N_LSB,
    input  logic                          i_operation_end,
    input  logic [COUNTER_BIT-1:0]        i_operation_count,
    input  logic [MAX_N_DIGIT/2-1:0]      i_X,
    input  logic [MAX_N_DIGIT/2-1:0]      i_Y,
    output logic                          o_res_valid,
    input  logic                          i_res_ready,
    output logic [MAX_N_DIGIT/2-1:0]      o_res_X,
    output logic [MAX_N_DIGIT/2-1:0]      o_res_Y,
    output logic                          o_res_found,
    output logic [7:0]                    o_res_attempts,
    output logic [COUNTER_BIT+7:0]        o_res_samples
);

    localparam int HW     = MAX_N_DIGIT / 2;
    localparam int SW     = COUNTER_BIT + 8;
    localparam int MID_W  = mid_w(MAX_N_DIGIT);
    localparam int MID_HI = mid_hi(MAX_N_DIGIT);
    localparam int LSB_W  = lsb_w(MAX_N_DIGIT);

    state_e                 state_q, state_d;
    logic [MAX_N_DIGIT-1:0] n_q, n_d;
    logic [31:0]            seed_q, seed_d;
    logic [HW-1:0]          x_q, x_d;
    logic [HW-1:0]          y_q, y_d;
    logic [7:0]             att_q, att_d;
    logic [SW-1:0]          samp_q, samp_d;
    logic                   found_q, found_d;
    logic [7:0]             cnt_q, cnt_d;

    logic [SW:0]            samp_sum;
    logic [SW-1:0]          samp_sat;
    logic                   end_seen;
    logic                   ok;

    factor_verify #(
        .MAX_N_DIGIT(MAX_N_DIGIT)
    ) u_verify (
        .clk (clk),
        .rst (rst),
        .i_x (x_q),
        .i_y (y_q),
        .i_n (n_q),
        .o_ok(ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            seed_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            att_q   <= '0;
            samp_q  <= '0;
            found_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            seed_q  <= seed_d;
            x_q     <= x_d;
            y_q     <= y_d;
            att_q   <= att_d;
            samp_q  <= samp_d;
            found_q <= found_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        seed_d   = seed_q;
        x_d      = x_q;
        y_d      = y_q;
        att_d    = att_q;
        samp_d   = samp_q;
        found_d  = found_q;
        cnt_d    = cnt_q + 8'd1;
        samp_sum = {1'b0, samp_q} + (SW+1)'(i_operation_count);
        samp_sat = samp_sum[SW] ? '1 : samp_sum[SW-1:0];
        // The core's end flag is stale on the first RUN cycle (cnt_q == 0).
        end_seen = i_operation_end && (cnt_q != 8'd0);
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_N_valid) begin
                    n_d     = i_N;
                    seed_d  = i_seed;
                    att_d   = '0;
                    samp_d  = '0;
                    found_d = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                    if (i_N < MAX_N_DIGIT'(4)) begin
                        state_d = S_RESULT;
                    end else if (!i_N[0]) begin
                        state_d = S_RESULT;
                        found_d = 1'b1;
                        x_d     = HW'(2);
                        y_d     = i_N[HW:1];
                    end else begin
                        state_d = S_INIT;
                    end
                end
            end
            S_INIT: begin
                if (cnt_q == 8'(INIT_CYCLES - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = 8'd1;
                if (i_abort) begin
                    state_d = S_RESULT;
                    found_d = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                    att_d   = att_q + 8'd1;
                    if (end_seen) samp_d = samp_sat;
                end else if (end_seen) begin
                    state_d = S_CHECK;
                    x_d     = i_X;
                    y_d     = i_Y;
                    samp_d  = samp_sat;
                    att_d   = att_q + 8'd1;
                    cnt_d   = '0;
                end
            end
            S_CHECK: begin
                if (cnt_q == 8'(VERIFY_LAT)) begin
                    cnt_d = '0;
                    if (ok) begin
                        state_d = S_RESULT;
                        found_d = 1'b1;
                    end else if (att_q == 8'(MAX_RETRY)) begin
                        state_d = S_RESULT;
                        found_d = 1'b0;
                        x_d     = '0;
                        y_d     = '0;
                    end else begin
                        state_d = S_INIT;
                        seed_d  = seed_q + SEED_STEP;
                    end
                end
            end
            S_RESULT: begin
                if (i_res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_N_ready      = (state_q == S_IDLE);
        o_core_en      = (state_q == S_RUN) || (state_q == S_CHECK);
        o_res_valid    = (state_q == S_RESULT);
        o_seed         = seed_q;
        o_N_MSB        = n_q[MAX_N_DIGIT-1 -: MSB_W];
        o_N_MID        = n_q[MID_HI -: MID_W];
        o_N_LSB        = n_q[LSB_W-1:0];
        o_res_X        = x_q;
        o_res_Y        = y_q;
        o_res_found    = found_q;
        o_res_attempts = att_q;
        o_res_samples  = samp_q;
    end

endmodule
